// File: rtl/flash_arbiter_pkg.sv
// Shared types for the two-port flash read arbiter.
// Round-robin arbitration is enabled with `define FLASH_ARB_RR_EN.
package flash_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } arb_state_t;

  localparam int FLASH_LATENCY_DEFAULT = 11;

  function automatic logic [1:0] port_sel(input logic id);
    return id ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/flash_arbiter_if.sv
// Requester and flash-side signals of the flash arbiter.
// slave: the arbiter; master: requesters plus flash model.
interface flash_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic [1:0]        req;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [1:0]        gnt;
  logic [1:0]        rdata_valid;
  logic [DATA_W-1:0] rdata;
  logic              busy;
  logic              flash_ready;
  logic [ADDR_W-1:0] flash_address;
  logic [DATA_W-1:0] flashData_out;

  modport slave (
    input  req, addr0, addr1, flashData_out,
    output gnt, rdata_valid, rdata, busy,
    output flash_ready, flash_address
  );

  modport master (
    output req, addr0, addr1, flashData_out,
    input  gnt, rdata_valid, rdata, busy,
    input  flash_ready, flash_address
  );
endinterface

// File: rtl/flash_arbiter_flex_counter.sv
// Clearable up-counter; flags the cycle that reaches rollover_val.
// Returns to zero on that cycle, so it never holds a value past the flag.
module flex_counter #(
  parameter int NUM_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    count_enable,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  output logic                    rollover_flag
);
  logic [NUM_CNT_BITS-1:0] count_q, count_d, inc;

  always_comb begin
    inc           = count_q + NUM_CNT_BITS'(1);
    rollover_flag = count_enable && !clear
                    && (inc == rollover_val);
    count_d       = count_q;
    if (clear)
      count_d = '0;
    else if (count_enable)
      count_d = rollover_flag ? '0 : inc;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) count_q <= '0;
    else        count_q <= count_d;
  end
endmodule

// File: rtl/flash_arbiter.sv
// Two-requester arbiter for the single fixed-latency flash read port.
// FLASH_ARB_RR_EN selects round-robin; default is port-0 priority.
module flash_arbiter
  import flash_arb_pkg::*;
#(
  parameter int LATENCY = FLASH_LATENCY_DEFAULT,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16
) (
  input logic             clk,
  input logic             n_rst,
  flash_arbiter_if.slave  bus
);
  localparam int CW = $clog2(LATENCY + 1);
  localparam logic [CW-1:0] ROLL = CW'(LATENCY);

  arb_state_t        state_q, state_d;
  logic              owner_q, owner_d, pick;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]        gnt_q, gnt_d;
  logic [1:0]        rv_q, rv_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              done;
`ifdef FLASH_ARB_RR_EN
  logic              last_q, last_d;
`endif

  flex_counter #(
    .NUM_CNT_BITS (CW)
  ) u_wait_cnt (
    .clk           (clk),
    .n_rst         (n_rst),
    .clear         (state_q == ISSUE),
    .count_enable  (state_q == WAIT),
    .rollover_val  (ROLL),
    .rollover_flag (done)
  );

  always_comb begin
`ifdef FLASH_ARB_RR_EN
    if (&bus.req) pick = ~last_q;
    else          pick = ~bus.req[0];
`else
    pick = ~bus.req[0];
`endif
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    addr_d  = addr_q;
    rdata_d = rdata_q;
`ifdef FLASH_ARB_RR_EN
    last_d  = last_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (|bus.req) begin
          owner_d = pick;
          addr_d  = pick ? bus.addr1 : bus.addr0;
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (done) begin
          rdata_d = bus.flashData_out;
          state_d = DONE;
        end
      end
      DONE: begin
`ifdef FLASH_ARB_RR_EN
        last_d  = owner_q;
`endif
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Outputs are decoded from the next state so they register cleanly.
    gnt_d   = (state_d == ISSUE) ? port_sel(owner_d) : 2'b00;
    rv_d    = (state_d == DONE)  ? port_sel(owner_d) : 2'b00;
    ready_d = (state_d == ISSUE);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      addr_q  <= '0;
      rdata_q <= '0;
      gnt_q   <= 2'b00;
      rv_q    <= 2'b00;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
`ifdef FLASH_ARB_RR_EN
      last_q  <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      rdata_q <= rdata_d;
      gnt_q   <= gnt_d;
      rv_q    <= rv_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
`ifdef FLASH_ARB_RR_EN
      last_q  <= last_d;
`endif
    end
  end

  assign bus.gnt           = gnt_q;
  assign bus.rdata_valid   = rv_q;
  assign bus.rdata         = rdata_q;
  assign bus.busy          = busy_q;
  assign bus.flash_ready   = ready_q;
  assign bus.flash_address = addr_q;
endmodule

// File: tb/tb_flash_arbiter.sv
// Scoreboard bench for flash_arbiter with a latency-exact flash model.
// Follows FLASH_ARB_RR_EN to pick contest expectations.
module tb_flash_arbiter;
  import flash_arb_pkg::*;

  localparam int LAT = FLASH_LATENCY_DEFAULT;
  localparam logic [15:0] KEY = 16'hA583;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  flash_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

  flash_arbiter #(
    .LATENCY (LAT),
    .ADDR_W  (16),
    .DATA_W  (16)
  ) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Flash returns good data only in the cycle exactly LAT after the strobe.
  int fcnt = 0;
  always @(posedge clk) begin
    if (bus.flash_ready)               fcnt <= 1;
    else if (fcnt != 0 && fcnt < 30)   fcnt <= fcnt + 1;
    else                               fcnt <= 0;
  end
  assign bus.flashData_out = (fcnt == LAT) ?
                             (bus.flash_address ^ KEY) : 16'hDEAD;

  typedef struct {
    int          port;
    logic [15:0] data;
    int          at;
  } exp_t;

  exp_t gq[$];
  exp_t rq[$];
  int checks = 0;
  int errors = 0;
  int rv_pulses = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic expect_read(input int p, input logic [15:0] d,
                             input int t);
    exp_t e;
    e.port = p; e.data = 16'h0; e.at = t;
    gq.push_back(e);
    e.data = d; e.at = t + LAT + 1;
    rq.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (bus.flash_ready || (|bus.gnt))
      chk("ready_vs_gnt", 32'(bus.flash_ready), 32'(|bus.gnt));
    if (|bus.gnt) begin
      if (gq.size() == 0) chk("gnt_unexpected", 32'(bus.gnt), 0);
      else begin
        e = gq.pop_front();
        chk("gnt_port", 32'(bus.gnt), (e.port == 1) ? 2 : 1);
        chk("gnt_cycle", cyc, e.at);
      end
    end
    if (|bus.rdata_valid) begin
      rv_pulses++;
      if (rq.size() == 0) chk("rv_unexpected", 32'(bus.rdata_valid), 0);
      else begin
        e = rq.pop_front();
        chk("rv_port", 32'(bus.rdata_valid), (e.port == 1) ? 2 : 1);
        chk("rv_data", 32'(bus.rdata), 32'(e.data));
        chk("rv_cycle", cyc, e.at);
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((bus.busy || gq.size() != 0 || rq.size() != 0) && n < 100);
    if (n >= 100) chk("idle_timeout", 1, 0);
  endtask

  task automatic wait_gnt(input int p);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.gnt[p] && n < 40);
    if (!bus.gnt[p]) chk("gnt_timeout", 0, 1);
    bus.req[p] = 1'b0;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_gnt"},   32'(bus.gnt), 0);
    chk({tag, "_rv"},    32'(bus.rdata_valid), 0);
    chk({tag, "_rdata"}, 32'(bus.rdata), 0);
    chk({tag, "_busy"},  32'(bus.busy), 0);
    chk({tag, "_ready"}, 32'(bus.flash_ready), 0);
    chk({tag, "_addr"},  32'(bus.flash_address), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int t;
    int f;
    int p;
    bus.req = 2'b00;
    bus.addr0 = 16'h0;
    bus.addr1 = 16'h0;
    repeat (2) @(negedge clk);
    chk_zero("rst");
    n_rst = 1'b1;
    @(negedge clk);

    // Contest straight out of reset: port 0 first.
    bus.addr0 = 16'h0100;
    bus.addr1 = 16'h0200;
    t = cyc;
    expect_read(0, 16'hA483, t + 1);
    expect_read(1, 16'hA783, t + 15);
    bus.req = 2'b11;
    wait_gnt(0);
    wait_gnt(1);
    wait_idle();

    // Single read from port 0.
    bus.addr0 = 16'h0040;
    t = cyc;
    expect_read(0, 16'hA5C3, t + 1);
    bus.req = 2'b01;
    wait_gnt(0);
    wait_idle();
    chk("rdata_held", 32'(bus.rdata), 32'h0000A5C3);

    // Contest after port 0 owned the port.
`ifdef FLASH_ARB_RR_EN
    f = 1;
`else
    f = 0;
`endif
    bus.addr0 = 16'h0500;
    bus.addr1 = 16'h0600;
    t = cyc;
    expect_read(f, (f == 1) ? 16'hA383 : 16'hA083, t + 1);
    expect_read(1 - f, (f == 1) ? 16'hA083 : 16'hA383, t + 15);
    bus.req = 2'b11;
    wait_gnt(f);
    wait_gnt(1 - f);
    wait_idle();

    // Late request from port 1 and address hold on port 0.
    bus.addr0 = 16'h0300;
    t = cyc;
    expect_read(0, 16'hA683, t + 1);
    expect_read(1, 16'hA183, t + 15);
    bus.req = 2'b01;
    wait_gnt(0);
    wait_until(t + 2);
    bus.addr0 = 16'hFFFF;
    wait_until(t + 5);
    bus.addr1 = 16'h0400;
    bus.req[1] = 1'b1;
    wait_until(t + 10);
    chk("addr_hold", 32'(bus.flash_address), 32'h00000300);
    wait_gnt(1);
    wait_until(t + 16);
    chk("addr_next", 32'(bus.flash_address), 32'h00000400);
    wait_until(t + 20);
    chk("rdata_prev_held", 32'(bus.rdata), 32'h0000A683);
    wait_idle();

    // Reset in the middle of WAIT aborts the read.
    bus.addr0 = 16'h0700;
    t = cyc;
    begin
      exp_t e;
      e.port = 0; e.data = 16'h0; e.at = t + 1;
      gq.push_back(e);
    end
    bus.req = 2'b01;
    wait_gnt(0);
    wait_until(t + 6);
    n_rst = 1'b0;
    #1;
    chk_zero("midrst");
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    bus.req = 2'b00;
    p = rv_pulses;
    repeat (20) @(negedge clk);
    chk("no_rv_after_rst", rv_pulses - p, 0);
    chk("busy_after_rst", 32'(bus.busy), 0);

    chk("gq_empty", gq.size(), 0);
    chk("rq_empty", rq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/flash_arbiter.md
# flash_arbiter

Shares the single external weight/bias flash port between two read requesters: port 0 is the network controller's weight/bias fetch and port 1 is the host/SPI readback path. It arbitrates, issues one fixed-latency read at a time (one-cycle `flash_ready` strobe plus a held address), waits the flash access latency, then returns the 16-bit word to the winning requester with a one-cycle valid pulse. It sits between the network controller and the flash model, taking over the address and ready generation that each requester would otherwise do itself.

## Interface
Parameters:
- `LATENCY`, 11: cycles from the `flash_ready` strobe to the cycle in which `flashData_out` is valid and sampled.
- `ADDR_W`, 16: flash address width.
- `DATA_W`, 16: flash data width.

Ports:
- `clk`  in  1  system clock, rising edge.
- `n_rst`  in  1  asynchronous, active-low reset.
- `req`  in  2  read request per requester; held high until that requester's `gnt`.
- `addr0`, `addr1`  in  ADDR_W  request addresses; held stable while the matching `req` is high.
- `gnt`  out  2  one-hot, one-cycle grant pulse.
- `rdata_valid`  out  2  one-hot, one-cycle pulse: `rdata` belongs to this requester.
- `rdata`  out  DATA_W  last captured flash word; held until the next capture.
- `busy`  out  1  high in every state except IDLE.
- `flash_ready`  out  1  one-cycle read strobe to flash.
- `flash_address`  out  ADDR_W  latched address of the current transaction.
- `flashData_out`  in  DATA_W  flash read data.

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE: if any `req` bit is high, select an owner, latch the owner id and its address into `flash_address`, and go to ISSUE. Otherwise stay in IDLE.
- ISSUE: `gnt[owner]`=1 and `flash_ready`=1 for this one cycle. Clear the wait counter. Go to WAIT.
- WAIT: the counter increments each cycle from 1. When count==`LATENCY`, capture `flashData_out` into `rdata` and go to DONE.
- DONE: `rdata_valid[owner]`=1 for one cycle. Update the last-owner pointer. Go to IDLE.
- `flash_address` holds its value from the latch until the next latch in IDLE. It does not return to 0 between transactions.
- Arbitration with both requests high: see Configuration. With a single request high, that requester wins.
- A requester dropping `req` after the IDLE sampling edge has no effect; the transaction it started still completes.
- A `req` asserted while `busy`=1 is evaluated at the next IDLE.
- Only one transaction is in flight at any time. There is no queueing beyond the `req` levels.
- Reset values: state IDLE, `gnt`=0, `rdata_valid`=0, `rdata`=0, `busy`=0, `flash_ready`=0, `flash_address`=0, owner=0, last-owner pointer=1 (so port 0 wins the first contest).
- Reset asserted mid-transaction: everything returns to the reset values immediately. No `rdata_valid` is produced for the aborted read.

## Timing
- `req` sampled high in IDLE at cycle T: `gnt` and `flash_ready` at T+1, WAIT from T+2 to T+1+`LATENCY`, `rdata_valid` at T+2+`LATENCY` (T+13 with the default).
- Data is captured at the end of cycle T+1+`LATENCY`. `rdata` is valid from T+2+`LATENCY` onward.
- Issue rate: one read per `LATENCY`+3 cycles (14 with the default). Back-to-back requests pass through IDLE for one cycle between transactions.
- `gnt`, `rdata_valid` and `flash_ready` are registered-state decodes: they are never asserted in the same cycle as the `req` edge.
- The wait counter is `$clog2(LATENCY+1)` bits wide. It is held at 0 outside WAIT and never wraps.

## Configuration
- `FLASH_ARB_RR_EN` defined: round-robin. On a contest, the requester that was not the last owner wins.
- Without it: fixed priority. Port 0 (network controller) always wins a contest, and the last-owner pointer is not implemented.

## Structure
- Package `flash_arb_pkg` holds the state enum `arb_state_t` (IDLE, ISSUE, WAIT, DONE) and `FLASH_LATENCY_DEFAULT` = 11.
- Sub-module: the wait counter is an instance of the existing `flex_counter`, with rollover_val = `LATENCY`, clear driven by the ISSUE state and count_enable driven by the WAIT state.
- Arbitration and the output decode live in the top module.

## Test plan
- Single read: `req`=01, `addr0`=0x0040 at T; flash model returns 0xA5C3 → `gnt`=01 at T+1, `flash_ready` high for exactly one cycle, `rdata_valid`=01 and `rdata`=0xA5C3 at T+13.
- Contest: `req`=11 from reset → port 0 served first; port 1 gets `gnt` at T+15 (`rdata_valid`=10 at T+27). Repeat the contest: with RR, port 0 and port 1 alternate; without RR, port 0 is served every time.
- Late request: `req`=10 raised while port 0's read is in WAIT → port 1 is granted the cycle after IDLE is re-entered, and `rdata` of the first transaction stays held until the second capture.
- Address hold: change `addr0` after `gnt` → `flash_address` is unchanged until the next transaction's IDLE sampling.
- Reset mid-WAIT: drop `n_rst` at T+6 → all outputs return to 0 asynchronously, and no `rdata_valid` appears within 20 cycles of `n_rst` rising again with `req`=00.
- `LATENCY`=3 build: `rdata_valid` at T+5 and the counter never exceeds 3.
